// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : instruction_fetch_unit_pkg                                |
// | Purpose  : Core-wide fetch constants, state encoding and helpers.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package instruction_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [1:0] FETCH_ENC = 2'b00;
  localparam logic [1:0] ISSUE_ENC = 2'b01;
  localparam logic [1:0] ERROR_ENC = 2'b10;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;

  typedef enum logic [1:0] {
    ST_FETCH = FETCH_ENC,
    ST_ISSUE = ISSUE_ENC,
    ST_ERROR = ERROR_ENC
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : instruction_fetch_unit_if                                 |
// | Purpose  : Instruction-memory req/ack fetch bus.                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Imem_Req_o;
  logic [DATA_WIDTH-1:0] Imem_Addr_o;
  logic                  Imem_Ack_i;
  logic [DATA_WIDTH-1:0] Imem_Data_i;

  modport master (
    output Imem_Req_o,
    output Imem_Addr_o,
    input  Imem_Ack_i,
    input  Imem_Data_i
  );

  modport slave (
    input  Imem_Req_o,
    input  Imem_Addr_o,
    output Imem_Ack_i,
    output Imem_Data_i
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit_pc_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pc_register                                               |
// | Purpose  : Loadable address register, async active-low reset.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pc_register #(
  parameter int                    WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (i_load) pc_d = i_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_VALUE;
    else        pc_q <= pc_d;
  end

  assign o_q = pc_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : instruction_fetch_unit                                    |
// | Purpose  : PC ownership, imem fetch and instruction register.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  Stall_i,
  input  wire logic                  Redirect_Valid_i,
  input  wire logic [DATA_WIDTH-1:0] Redirect_PC_i,
  instruction_fetch_unit_if.master   imem,
  output logic                       Instr_Valid_o,
  output logic      [DATA_WIDTH-1:0] Instr_o,
  output logic      [6:0]            Opcode_o,
  output logic      [DATA_WIDTH-1:0] PC_o,
  output logic      [DATA_WIDTH-1:0] PC_Plus_4_o,
  output logic                       Fetch_Error_o
);

  fetch_state_e          state_q, state_d;
  logic                  req_q, req_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;

  logic                  w_fetch_pc_load;
  logic [DATA_WIDTH-1:0] w_fetch_pc_next;
  logic [DATA_WIDTH-1:0] w_fetch_pc;
  logic                  w_pc_load;
  logic [DATA_WIDTH-1:0] w_pc;
  logic [DATA_WIDTH-1:0] w_pc_plus_4;

  assign w_pc_plus_4 = w_pc + DATA_WIDTH'(4);

  // req_q gates the capture so an ack arriving before the first request
  // after reset (or one left over from an abandoned fetch) is ignored.
  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    err_d           = err_q;
    w_fetch_pc_load = 1'b0;
    w_fetch_pc_next = w_pc_plus_4;
    w_pc_load       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (req_q && imem.Imem_Ack_i) begin
          instr_d   = imem.Imem_Data_i;
          w_pc_load = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!Stall_i) begin
          if (Redirect_Valid_i) begin
            if (is_word_aligned(Redirect_PC_i[1:0])) begin
              w_fetch_pc_load = 1'b1;
              w_fetch_pc_next = Redirect_PC_i;
              state_d         = ST_FETCH;
            end else begin
              err_d   = 1'b1;
              state_d = ST_ERROR;
            end
          end else begin
            w_fetch_pc_load = 1'b1;
            state_d         = ST_FETCH;
          end
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
      end
    endcase
    req_d   = (state_d == ST_FETCH);
    valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      instr_q <= DATA_WIDTH'(NOP_INSTR);
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      instr_q <= instr_d;
    end
  end

  pc_register #(
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (RESET_PC)
  ) u_fetch_pc (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_fetch_pc_load),
    .i_d    (w_fetch_pc_next),
    .o_q    (w_fetch_pc)
  );

  pc_register #(
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (RESET_PC)
  ) u_instr_pc (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_pc_load),
    .i_d    (w_fetch_pc),
    .o_q    (w_pc)
  );

  assign imem.Imem_Req_o  = req_q;
  assign imem.Imem_Addr_o = w_fetch_pc;
  assign Instr_Valid_o    = valid_q;
  assign Instr_o          = instr_q;
  assign Opcode_o         = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign PC_o             = w_pc;
  assign PC_Plus_4_o      = w_pc_plus_4;
  assign Fetch_Error_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_instruction_fetch_unit                                 |
// | Purpose  : Directed self-checking bench for instruction_fetch_unit.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall_i;
  logic        Redirect_Valid_i;
  logic [31:0] Redirect_PC_i;
  logic        Instr_Valid_o;
  logic [31:0] Instr_o;
  logic [6:0]  Opcode_o;
  logic [31:0] PC_o;
  logic [31:0] PC_Plus_4_o;
  logic        Fetch_Error_o;

  logic        auto_ack;
  logic        man_ack;
  logic [31:0] man_data;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch_unit_if #(.DATA_WIDTH(32)) imem_bus ();

  instruction_fetch_unit #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0040_0000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .Stall_i          (Stall_i),
    .Redirect_Valid_i (Redirect_Valid_i),
    .Redirect_PC_i    (Redirect_PC_i),
    .imem             (imem_bus),
    .Instr_Valid_o    (Instr_Valid_o),
    .Instr_o          (Instr_o),
    .Opcode_o         (Opcode_o),
    .PC_o             (PC_o),
    .PC_Plus_4_o      (PC_Plus_4_o),
    .Fetch_Error_o    (Fetch_Error_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h0050_0093;
    if (a == 32'h0040_0004) return 32'h0010_0113;
    return {a[24:0], 7'b0110111};
  endfunction

  // Zero-wait memory model when auto_ack is set, otherwise hand-driven.
  assign imem_bus.Imem_Ack_i  = auto_ack ? imem_bus.Imem_Req_o : man_ack;
  assign imem_bus.Imem_Data_i = auto_ack ? mem_word(imem_bus.Imem_Addr_o) : man_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    chk("rst_valid", 32'(Instr_Valid_o), 32'd0);
    chk("rst_instr", Instr_o, 32'h0000_0013);
    chk("rst_opcode", 32'(Opcode_o), 32'h13);
    chk("rst_pc", PC_o, 32'h0040_0000);
    chk("rst_pc4", PC_Plus_4_o, 32'h0040_0004);
    chk("rst_err", 32'(Fetch_Error_o), 32'd0);
    chk("rst_req", 32'(imem_bus.Imem_Req_o), 32'd0);
    reset = 1'b1;
  endtask

  task automatic test_zero_wait();
    auto_ack = 1'b1;
    tick();
    chk("zw_req0", 32'(imem_bus.Imem_Req_o), 32'd1);
    chk("zw_addr0", imem_bus.Imem_Addr_o, 32'h0040_0000);
    chk("zw_valid0", 32'(Instr_Valid_o), 32'd0);
    tick();
    chk("zw_valid1", 32'(Instr_Valid_o), 32'd1);
    chk("zw_req1", 32'(imem_bus.Imem_Req_o), 32'd0);
    chk("zw_instr1", Instr_o, 32'h0050_0093);
    chk("zw_opcode1", 32'(Opcode_o), 32'h13);
    chk("zw_pc1", PC_o, 32'h0040_0000);
    tick();
    chk("zw_valid2", 32'(Instr_Valid_o), 32'd0);
    chk("zw_addr2", imem_bus.Imem_Addr_o, 32'h0040_0004);
    tick();
    chk("zw_valid3", 32'(Instr_Valid_o), 32'd1);
    chk("zw_instr3", Instr_o, 32'h0010_0113);
    chk("zw_pc3", PC_o, 32'h0040_0004);
    tick();
    chk("zw_req4", 32'(imem_bus.Imem_Req_o), 32'd1);
    chk("zw_addr4", imem_bus.Imem_Addr_o, 32'h0040_0008);
    auto_ack = 1'b0;
    man_ack  = 1'b0;
  endtask

  task automatic test_wait_ack();
    for (int i = 0; i < 3; i++) begin
      chk("wa_req", 32'(imem_bus.Imem_Req_o), 32'd1);
      chk("wa_addr", imem_bus.Imem_Addr_o, 32'h0040_0008);
      chk("wa_valid", 32'(Instr_Valid_o), 32'd0);
      tick();
    end
    chk("wa_req_last", 32'(imem_bus.Imem_Req_o), 32'd1);
    chk("wa_addr_last", imem_bus.Imem_Addr_o, 32'h0040_0008);
    man_ack          = 1'b1;
    man_data         = 32'h00A0_0513;
    Stall_i          = 1'b1;
    Redirect_Valid_i = 1'b1;
    Redirect_PC_i    = 32'h0040_0100;
    tick();
    man_ack = 1'b0;
    chk("wa_valid_rise", 32'(Instr_Valid_o), 32'd1);
    chk("wa_instr", Instr_o, 32'h00A0_0513);
    chk("wa_pc", PC_o, 32'h0040_0008);
  endtask

  task automatic test_stall_redirect();
    for (int i = 0; i < 5; i++) begin
      man_ack  = (i == 2);
      man_data = 32'hDEAD_BEEF;
      tick();
      chk("st_req", 32'(imem_bus.Imem_Req_o), 32'd0);
      chk("st_valid", 32'(Instr_Valid_o), 32'd1);
      chk("st_instr", Instr_o, 32'h00A0_0513);
      chk("st_pc", PC_o, 32'h0040_0008);
    end
    man_ack = 1'b0;
    Stall_i = 1'b0;
    tick();
    chk("rd_req", 32'(imem_bus.Imem_Req_o), 32'd1);
    chk("rd_addr", imem_bus.Imem_Addr_o, 32'h0040_0100);
    Redirect_PC_i = 32'h0040_0102;
    man_ack       = 1'b1;
    man_data      = 32'h0000_0067;
    tick();
    man_ack = 1'b0;
    chk("rd_pc", PC_o, 32'h0040_0100);
    chk("rd_opcode", 32'(Opcode_o), 32'h67);
  endtask

  task automatic test_error();
    tick();
    for (int i = 0; i < 20; i++) begin
      man_ack = (i == 4);
      chk("er_err", 32'(Fetch_Error_o), 32'd1);
      chk("er_req", 32'(imem_bus.Imem_Req_o), 32'd0);
      chk("er_valid", 32'(Instr_Valid_o), 32'd0);
      tick();
    end
    man_ack          = 1'b0;
    Redirect_Valid_i = 1'b0;
    reset            = 1'b0;
    #1;
    chk("er_rst_err", 32'(Fetch_Error_o), 32'd0);
    chk("er_rst_instr", Instr_o, 32'h0000_0013);
    tick();
    reset = 1'b1;
    tick();
    chk("er_refetch_req", 32'(imem_bus.Imem_Req_o), 32'd1);
    chk("er_refetch_addr", imem_bus.Imem_Addr_o, 32'h0040_0000);
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    #1;
    man_ack  = 1'b1;
    man_data = 32'h1234_5677;
    tick();
    tick();
    chk("rm_valid", 32'(Instr_Valid_o), 32'd0);
    chk("rm_instr", Instr_o, 32'h0000_0013);
    chk("rm_req", 32'(imem_bus.Imem_Req_o), 32'd0);
    man_ack = 1'b0;
    reset   = 1'b1;
    tick();
    chk("rm_req_after", 32'(imem_bus.Imem_Req_o), 32'd1);
    chk("rm_addr_after", imem_bus.Imem_Addr_o, 32'h0040_0000);
    chk("rm_valid_after", 32'(Instr_Valid_o), 32'd0);
  endtask

  task automatic test_wrap();
    man_ack          = 1'b1;
    man_data         = 32'h0000_0013;
    Redirect_Valid_i = 1'b1;
    Redirect_PC_i    = 32'hFFFF_FFFC;
    tick();
    man_ack = 1'b0;
    tick();
    chk("wr_addr_top", imem_bus.Imem_Addr_o, 32'hFFFF_FFFC);
    Redirect_Valid_i = 1'b0;
    man_ack          = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("wr_pc", PC_o, 32'hFFFF_FFFC);
    chk("wr_pc4", PC_Plus_4_o, 32'h0000_0000);
    tick();
    chk("wr_addr_wrap", imem_bus.Imem_Addr_o, 32'h0000_0000);
    chk("wr_req", 32'(imem_bus.Imem_Req_o), 32'd1);
    chk("wr_err", 32'(Fetch_Error_o), 32'd0);
  endtask

  initial begin
    reset            = 1'b0;
    Stall_i          = 1'b0;
    Redirect_Valid_i = 1'b0;
    Redirect_PC_i    = 32'h0;
    auto_ack         = 1'b0;
    man_ack          = 1'b0;
    man_data         = 32'h0;
    tick();
    tick();
    test_reset();
    test_zero_wait();
    test_wait_ack();
    test_stall_redirect();
    test_error();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end stage of the RISC-V core. Owns the program counter and fetches instructions from instruction memory over a req/ack handshake.
- Holds the current instruction in an instruction register and presents its opcode field to the control unit, which sits directly downstream.
- Accepts stall and taken-branch/jump redirect from the execute side.

Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset.
- DATA_WIDTH, 32, instruction and address width.

Ports:
- clk  input  1  single core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Stall_i  input  1  hold the current instruction; no new fetch.
- Redirect_Valid_i  input  1  taken branch/jump for the current instruction.
- Redirect_PC_i  input  32  target address for the redirect.
- Imem_Req_o  output  1  fetch request to instruction memory.
- Imem_Addr_o  output  32  fetch address; stable while Imem_Req_o=1.
- Imem_Ack_i  input  1  memory has returned data this cycle.
- Imem_Data_i  input  32  instruction word, valid when Imem_Ack_i=1.
- Instr_Valid_o  output  1  Instr_o/PC_o hold a fetched, not-yet-retired instruction.
- Instr_o  output  32  instruction register.
- Opcode_o  output  7  Instr_o[6:0], feeds the control unit opcode input.
- PC_o  output  32  address of Instr_o.
- PC_Plus_4_o  output  32  PC_o+4, for JAL/JALR link.
- Fetch_Error_o  output  1  sticky misaligned-redirect error.

Behaviour:
- Reset is asynchronous and active-low; it applies immediately, independent of clk. Values while reset=0:
  - state=FETCH, fetch_pc=RESET_PC
  - Instr_Valid_o=0, Instr_o=32'h0000_0013 (NOP), PC_o=RESET_PC
  - Fetch_Error_o=0, Imem_Req_o=0
- First rising edge after reset release: Imem_Req_o=1 with Imem_Addr_o=RESET_PC.
- Reset asserted mid-handshake abandons the fetch; any later Ack is ignored.
- States: FETCH, ISSUE, ERROR. 2-bit encoding: FETCH=00, ISSUE=01, ERROR=10.
- FETCH:
  - Imem_Req_o=1, Imem_Addr_o=fetch_pc, Instr_Valid_o=0.
  - Imem_Ack_i=1 at edge: Instr_o<=Imem_Data_i, PC_o<=fetch_pc, go to ISSUE.
  - Latency: Ack in cycle N gives Instr_Valid_o=1 in cycle N+1.
  - Redirect_Valid_i and Stall_i are ignored in FETCH.
- ISSUE:
  - Imem_Req_o=0, Instr_Valid_o=1, Instr_o and PC_o held.
  - Stall_i=1: remain in ISSUE; everything held. Stall has priority over redirect.
  - Stall_i=0, Redirect_Valid_i=1, Redirect_PC_i[1:0]==00: fetch_pc<=Redirect_PC_i, go to FETCH.
  - Stall_i=0, Redirect_Valid_i=1, Redirect_PC_i[1:0]!=00: go to ERROR, Fetch_Error_o<=1.
  - Stall_i=0, Redirect_Valid_i=0: fetch_pc<=PC_o+4, go to FETCH.
- ERROR:
  - Imem_Req_o=0, Instr_Valid_o=0, Fetch_Error_o=1.
  - Exit only by reset.
- Imem_Ack_i outside FETCH is ignored; no capture, no state change.
- Arithmetic:
  - PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0, no error.
  - Opcode_o and PC_Plus_4_o are combinational from registered state.
- Throughput: zero-wait memory (Ack in same cycle as Req) gives one instruction per 2 cycles. Each wait cycle adds one.
- Instr_o/Opcode_o keep the last captured value while Instr_Valid_o=0; control consumers qualify with Instr_Valid_o.

Decomposition:
- Shared package (core-wide):
  - RESET_PC default
  - NOP_INSTR=32'h0000_0013
  - fetch state encoding localparams
  - OPCODE_LSB/MSB field positions
- One sub-module: pc_register. 32-bit register with async active-low reset to a parameter value and a load enable. Instantiated for fetch_pc and PC_o.

Test Plan:
- Reset release, memory acks every Req in the same cycle with data i0=0x00500093 at 0x00400000, i1 at 0x00400004 -> Imem_Addr_o sequence 0x00400000, 0x00400004, 0x00400008. Instr_Valid_o high every other cycle. Opcode_o=7'b0010011 with PC_o=0x00400000.
- Ack delayed 3 cycles -> Imem_Addr_o stable and Req high all 4 cycles. Instr_Valid_o rises exactly one cycle after Ack.
- In ISSUE: Stall_i=1 for 5 cycles with Redirect_Valid_i=1 -> no Req, Instr_o and PC_o unchanged. On the first cycle with Stall_i=0 and redirect still high, the next fetch address is Redirect_PC_i (0x00400100).
- Redirect to 0x00400102 -> ERROR: Fetch_Error_o=1, Req=0, Instr_Valid_o=0 for 20 cycles. After reset pulse: fetch from 0x00400000, error cleared.
- Reset asserted while Req pending, then Ack pulses during reset -> Instr_Valid_o=0, Instr_o=0x00000013. After release, first fetch is at RESET_PC.
- PC_o=0xFFFFFFFC, no redirect -> next Imem_Addr_o=0x00000000, PC_Plus_4_o=0x00000000.
